// File: rtl/bcd_display_counter.sv
// bcd_display_counter
//
// Multi-digit BCD up/down counter with a count prescaler and a time-multiplexed
// driver for an 8-digit, common-anode seven-segment display.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked). Without it every enabled digit shows its value.
//
// Parameters
//   DIGITS   : number of BCD digits counted and displayed (1..8)
//   TICK_DIV : clk cycles per count step
//   SCAN_DIV : clk cycles per display digit slot
//
// Ports
//   clk      in   system clock, rising edge
//   Resetn   in   asynchronous active-low reset
//   en       in   count enable (prescaler and counter hold while 0)
//   up_dn    in   1 = count up, 0 = count down (sampled on the tick cycle)
//   clr      in   synchronous clear (highest priority)
//   load     in   synchronous parallel load (nibbles above 9 stored as 9)
//   load_val in   BCD load value, digit 0 in [3:0]
//   count    out  current BCD count, digit 0 in [3:0]
//   carry    out  one-cycle pulse when the count wraps in either direction
//   AN       out  digit anodes, active low, one-hot low on the active digit
//   CX       out  segments {a,b,c,d,e,f,g,dp}, active low, dp always 1
//
// Handshake: none. Outputs are registered every cycle; AN and CX are captured
// in the same register stage so they always refer to the same digit.
module bcd_display_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic                  clk,
  input  logic                  Resetn,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic [7:0]            AN,
  output logic [7:0]            CX
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [2:0]    DIG_MAX   = 3'(DIGITS - 1);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                carry_q, carry_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic [2:0]          dig_q, dig_d;
  logic [7:0]          an_q, an_d;
  logic [7:0]          cx_q, cx_d;

  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] sat_val;
  logic                step_wrap;
  logic                rip;
  logic [3:0]          nib;
  logic [3:0]          cur_nib;
  logic                tick;
`ifdef LEADING_ZERO_BLANK_EN
  logic                upper_zero;
`endif

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'b00000011;
      4'd1:    seg7 = 8'b10011111;
      4'd2:    seg7 = 8'b00100101;
      4'd3:    seg7 = 8'b00001101;
      4'd4:    seg7 = 8'b10011001;
      4'd5:    seg7 = 8'b01001001;
      4'd6:    seg7 = 8'b01000001;
      4'd7:    seg7 = 8'b00011111;
      4'd8:    seg7 = 8'b00000001;
      4'd9:    seg7 = 8'b00001001;
      default: seg7 = 8'b11111111;
    endcase
  endfunction

  // Ripple BCD step: the ripple bit starts set and is cleared by the first
  // digit that does not roll over; if it survives every digit the count wrapped.
  always_comb begin
    step_val = count_q;
    rip      = 1'b1;
    nib      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = count_q[4*i +: 4];
      if (rip) begin
        if (up_dn) begin
          if (nib >= 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = nib + 4'd1;
            rip = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = nib - 4'd1;
            rip = 1'b0;
          end
        end
      end
    end
    step_wrap = rip;
  end

  // Load value with each nibble saturated to 9 so count stays valid BCD.
  always_comb begin
    sat_val = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) sat_val[4*i +: 4] = 4'd9;
    end
  end

  // With en low the prescaler holds, so a pending tick waits for en to return.
  assign tick = en && (presc_q == PRESC_MAX);

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    presc_d = presc_q;
    if (clr) begin
      count_d = '0;
      presc_d = '0;
    end else if (load) begin
      count_d = sat_val;
      presc_d = '0;
    end else if (en) begin
      if (tick) begin
        presc_d = '0;
        count_d = step_val;
        carry_d = step_wrap;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Scan timing runs regardless of en.
  always_comb begin
    dig_d = dig_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      dig_d  = (dig_q == DIG_MAX) ? 3'd0 : dig_q + 3'd1;
    end else begin
      scan_d = scan_q + SW'(1);
    end
  end

  // Display capture: both AN and CX come from the current digit index.
  always_comb begin
    cur_nib = 4'd0;
    an_d    = 8'hFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q == 3'(i)) begin
        cur_nib = count_q[4*i +: 4];
        an_d[i] = 1'b0;
      end
    end
    cx_d = seg7(cur_nib);
`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; a digit blanks while all digits at and
    // above it are zero. Digit 0 is never considered.
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (count_q[4*i +: 4] == 4'd0);
      if ((dig_q == 3'(i)) && upper_zero) cx_d = 8'hFF;
    end
`endif
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      count_q <= '0;
      carry_q <= 1'b0;
      presc_q <= '0;
      scan_q  <= '0;
      dig_q   <= 3'd0;
      an_q    <= 8'b11111110;
      cx_q    <= 8'b00000011;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      presc_q <= presc_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      cx_q    <= cx_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;
  assign AN    = an_q;
  assign CX    = cx_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Testbench for bcd_display_counter with DIGITS=2, TICK_DIV=4, SCAN_DIV=3.
// The driver applies one input set per cycle on the falling edge and pushes the
// expected post-edge outputs, computed by a decimal-integer reference model,
// into exp_q. A separate monitor pops one entry shortly after each rising edge
// and compares count, carry, AN and CX.
module tb_bcd_display_counter;
  localparam int D = 2;
  localparam int T = 4;
  localparam int S = 3;
  localparam int W = 4*D + 17;

  logic           clk = 1'b0;
  logic           Resetn = 1'b0;
  logic           en = 1'b0;
  logic           up_dn = 1'b0;
  logic           clr = 1'b0;
  logic           load = 1'b0;
  logic [4*D-1:0] load_val = '0;
  logic [4*D-1:0] count;
  logic           carry;
  logic [7:0]     AN;
  logic [7:0]     CX;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state: the count is a plain decimal integer.
  int m_cnt   = 0;
  int m_presc = 0;
  int m_scan  = 0;
  int m_dig   = 0;

  // Clock / reset
  always #5 clk = ~clk;

  bcd_display_counter #(.DIGITS(D), .TICK_DIV(T), .SCAN_DIV(S)) dut (
    .clk      (clk),
    .Resetn   (Resetn),
    .en       (en),
    .up_dn    (up_dn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .carry    (carry),
    .AN       (AN),
    .CX       (CX)
  );

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] seg_of(input int v);
    case (v)
      0: return 8'b00000011;
      1: return 8'b10011111;
      2: return 8'b00100101;
      3: return 8'b00001101;
      4: return 8'b10011001;
      5: return 8'b01001001;
      6: return 8'b01000001;
      7: return 8'b00011111;
      8: return 8'b00000001;
      9: return 8'b00001001;
      default: return 8'b11111111;
    endcase
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int load_to_int(input logic [4*D-1:0] lv);
    int r;
    int n;
    r = 0;
    for (int i = 0; i < D; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      r = r + n * pow10(i);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs just driven and queue the
  // outputs the DUT should present after the coming rising edge.
  task automatic model_push();
    int dv;
    logic [7:0] an_n;
    logic [7:0] cx_n;
    logic carry_n;
    dv   = (m_cnt / pow10(m_dig)) % 10;
    an_n = ~(8'd1 << m_dig);
    cx_n = seg_of(dv);
`ifdef LEADING_ZERO_BLANK_EN
    if (m_dig > 0 && m_cnt < pow10(m_dig)) cx_n = 8'hFF;
`endif
    carry_n = 1'b0;
    if (clr) begin
      m_cnt = 0;
      m_presc = 0;
    end else if (load) begin
      m_cnt = load_to_int(load_val);
      m_presc = 0;
    end else if (en) begin
      if (m_presc == T - 1) begin
        m_presc = 0;
        if (up_dn) begin
          if (m_cnt == pow10(D) - 1) begin m_cnt = 0; carry_n = 1'b1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = pow10(D) - 1; carry_n = 1'b1; end
          else m_cnt = m_cnt - 1;
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end
    if (m_scan == S - 1) begin
      m_scan = 0;
      m_dig = (m_dig + 1) % D;
    end else begin
      m_scan = m_scan + 1;
    end
    exp_q.push_back({to_bcd(m_cnt), carry_n, an_n, cx_n});
  endtask

  // Driver tasks
  task automatic cyc(input logic e, input logic u, input logic c, input logic l,
                     input logic [4*D-1:0] lv);
    @(negedge clk);
    en = e; up_dn = u; clr = c; load = l; load_val = lv;
    model_push();
  endtask

  // Asynchronous reset away from the rising edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    Resetn = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_AN", 32'(AN), 32'h000000FE);
    check("rst_CX", 32'(CX), 32'h00000003);
    m_cnt = 0; m_presc = 0; m_scan = 0; m_dig = 0;
    @(negedge clk);
    Resetn = 1'b1;
    en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    model_push();
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", 32'(count), 32'(e[W-1 -: 4*D]));
        check("carry", 32'(carry), 32'(e[16]));
        check("AN", 32'(AN), 32'(e[15:8]));
        check("CX", 32'(CX), 32'(e[7:0]));
      end
    end
  end

  // Stimulus
  initial begin
    logic r_en;
    logic r_up;
    logic r_clr;
    logic r_load;
    logic [4*D-1:0] r_lv;

    do_reset();
    // Count up across the 09 -> 10 BCD boundary.
    repeat (40) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Wrap up from 99.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Wrap down from 00.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    // Saturating load, then clr beats load.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h42);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    // en dropped exactly on the tick cycle, with up_dn toggling meanwhile.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h19);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    // Hold 37 and watch the scan.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h37);
    repeat (12) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    // Hold 05 (leading-zero case) and reset mid-scan.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
    repeat (7) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    do_reset();
    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      r_en   = ($urandom_range(0, 9) != 0);
      r_up   = 1'($urandom_range(0, 1));
      r_clr  = ($urandom_range(0, 59) == 0);
      r_load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) r_lv = r_up ? 8'h98 : 8'h01;
      else r_lv = 8'($urandom);
      cyc(r_en, r_up, r_clr, r_load, r_lv);
      if (k == 300) do_reset();
    end
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
